req_front_queue: RTL and testbench

- Upstream front-end for random_arbiter.
- Buffers per-requestor payloads in small FIFOs and drives the arbiter's req vector from FIFO non-empty status.
- Pops the granted head entry and forwards it downstream tagged with requestor id.
- Runs per-port wait counters that flag starvation once a head entry has waited K cycles; this gives the bound checked against the arbiter's grant behaviour.

---
 rtl/req_front_queue.sv | 137 +++++++++++++
 tb/tb_req_front_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_front_queue.sv
// Request front-end for random_arbiter: per-port FIFOs feed the req vector, the granted head is
// forwarded with its port id, and per-port wait counters raise starve after K ungranted cycles.
module req_front_queue #(
    parameter int NUM_REQS = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int K        = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQS-1:0]           in_valid,
    output logic [NUM_REQS-1:0]           in_ready,
    input  logic [NUM_REQS*DATA_W-1:0]    in_data,
    output logic [NUM_REQS-1:0]           req,
    input  logic [NUM_REQS-1:0]           grant,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(NUM_REQS)-1:0]   out_id,
    output logic [NUM_REQS-1:0]           starve,
    output logic                          protocol_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(K + 1);
    localparam int ID_W   = $clog2(NUM_REQS);

    logic [DATA_W-1:0] mem      [NUM_REQS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NUM_REQS];
    logic [PTR_W-1:0]  rd_ptr   [NUM_REQS];
    logic [CNT_W-1:0]  count    [NUM_REQS];
    logic [WAIT_W-1:0] wait_cnt [NUM_REQS];

    logic [NUM_REQS-1:0] push;
    logic [NUM_REQS-1:0] pop;
    logic [NUM_REQS-1:0] wait_clr;
    logic                multi_grant;
    logic                unreq_grant;
    logic                grant_err;
    logic                grant_ok;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   head_data;

    // Handshake status is a pure decode of the counts, so no input reaches in_ready or req.
    always_comb begin
        in_ready = '0;
        req      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            in_ready[i] = (count[i] != CNT_W'(DEPTH));
            req[i]      = (count[i] != '0);
        end
    end

    assign multi_grant = |(grant & (grant - NUM_REQS'(1)));
    assign unreq_grant = |(grant & ~req);
    assign grant_err   = multi_grant | unreq_grant;
    assign grant_ok    = (|grant) & ~grant_err;
    assign pop         = grant_ok ? grant : '0;
    assign push        = in_valid & in_ready;
    assign wait_clr    = ~req | pop;

    always_comb begin
        grant_idx = '0;
        head_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                head_data = mem[i][rd_ptr[i]];
            end
        end
    end

    // Payload storage carries no reset; validity is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rst) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // starve clears on the same edge as its counter so a grant drops it the very next cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rst || wait_clr[i]) begin
                wait_cnt[i] <= '0;
                starve[i]   <= 1'b0;
            end else begin
                if (wait_cnt[i] != WAIT_W'(K)) begin
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                end
                starve[i] <= (wait_cnt[i] == WAIT_W'(K));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= '0;
            protocol_err <= 1'b0;
        end else begin
            out_valid <= grant_ok;
            if (grant_ok) begin
                out_data <= head_data;
                out_id   <= grant_idx;
            end
            if (grant_err) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_req_front_queue.sv
// Bench for req_front_queue: reference FIFO queues predict req/in_ready and a scoreboard of
// forwarded entries is checked cycle-exactly against out_valid/out_data/out_id.
module tb_req_front_queue;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int KK = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*8-1:0] in_data;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [1:0]    out_id;
    logic [N-1:0]  starve;
    logic          protocol_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[N][$];
    logic       perr_m;

    req_front_queue #(.NUM_REQS(N), .DATA_W(8), .DEPTH(D), .K(KK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req(req), .grant(grant), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .starve(starve), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
            end
            if (exp_v) begin
                e = sb.pop_front();
                checks++;
                if ({out_id, out_data} !== {e.id, e.data}) begin
                    errors++;
                    $display("FAIL out_payload cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                             cyc, out_id, out_data, e.id, e.data);
                end
            end
        end
    end

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [N-1:0] m_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    // Applies one cycle of inputs, advances the reference model, returns just after the next negedge.
    task automatic drive(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic [N-1:0] g,
                         input logic r = 1'b0);
        logic [N-1:0] mreq;
        logic [N-1:0] mrdy;
        logic         err;
        exp_t         e;
        in_valid = v;
        in_data  = d;
        grant    = g;
        rst      = r;
        if (r) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            perr_m = 1'b0;
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end else begin
            mreq = m_req();
            mrdy = m_rdy();
            err  = ((g & (g - 4'd1)) != 0) || ((g & ~mreq) != 0);
            if (err) begin
                perr_m = 1'b1;
            end else if (g != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (g[i]) begin
                        e.due  = cyc + 1;
                        e.id   = 2'(i);
                        e.data = mq[i].pop_front();
                        sb.push_back(e);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && mrdy[i]) mq[i].push_back(d[i*8 +: 8]);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive('0, '0, '0, 1'b1);
        mon_en = 1'b1;
        drive('0, '0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            drive('0, '0, '0);
            checks++;
            if ({req, in_ready, starve, protocol_err} !== {4'b0000, 4'b1111, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle c=%0d got req=%b rdy=%b starve=%b perr=%b",
                         c, req, in_ready, starve, protocol_err);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] b;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'((j + 1) * 17 + r * 64);
                drive(4'b0100, {8'h00, b, 16'h0000}, '0);
            end
            checks++;
            if ({req, in_ready} !== {4'b0100, 4'b1011}) begin
                errors++;
                $display("FAIL fill_full r=%0d got req=%b rdy=%b", r, req, in_ready);
            end
            drive(4'b0100, {8'h00, 8'h55, 16'h0000}, '0);
            checks++;
            if ({req, in_ready} !== {m_req(), m_rdy()} || in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL fill_overflow r=%0d got req=%b rdy=%b", r, req, in_ready);
            end
            for (int j = 0; j < 4; j++) drive('0, '0, 4'b0100);
            drive('0, '0, '0);
            checks++;
            if ({req, in_ready} !== {4'b0000, 4'b1111}) begin
                errors++;
                $display("FAIL drain_empty r=%0d got req=%b rdy=%b", r, req, in_ready);
            end
        end
    endtask

    task automatic test_same_cycle();
        drive(4'b0001, {24'h0, 8'hA0}, '0);
        drive(4'b0001, {24'h0, 8'hA1}, 4'b0001);
        checks++;
        if ({req, in_ready} !== {4'b0001, 4'b1111}) begin
            errors++;
            $display("FAIL pushpop_one got req=%b rdy=%b", req, in_ready);
        end
        drive('0, '0, 4'b0001);
        checks++;
        if (req !== 4'b0000) begin
            errors++;
            $display("FAIL pushpop_one_drain got req=%b exp=0000", req);
        end
        for (int j = 0; j < 4; j++) drive(4'b0010, {16'h0, 8'(8'hB0 + j), 8'h0}, '0);
        checks++;
        if (in_ready !== 4'b1101) begin
            errors++;
            $display("FAIL full_before_pop got rdy=%b exp=1101", in_ready);
        end
        drive(4'b0010, {16'h0, 8'hB4, 8'h0}, 4'b0010);
        checks++;
        if ({req, in_ready} !== {m_req(), m_rdy()} || in_ready !== 4'b1111) begin
            errors++;
            $display("FAIL full_pushpop got req=%b rdy=%b exp rdy=1111", req, in_ready);
        end
        for (int j = 0; j < 3; j++) drive('0, '0, 4'b0010);
        drive('0, '0, '0);
        checks++;
        if (req !== 4'b0000) begin
            errors++;
            $display("FAIL full_pushpop_drain got req=%b exp=0000", req);
        end
    endtask

    task automatic test_starvation();
        logic [N-1:0] exp_s;
        drive(4'b1001, {8'hD0, 16'h0, 8'hE0}, '0);
        for (int k = 1; k <= KK + 2; k++) begin
            drive(4'b1000, {8'(k), 24'h0}, 4'b1000);
            exp_s = {3'b000, (k >= KK + 1)};
            checks++;
            if (starve !== exp_s) begin
                errors++;
                $display("FAIL starve_rise k=%0d got=%b exp=%b", k, starve, exp_s);
            end
        end
        drive('0, '0, 4'b0001);
        checks++;
        if ({starve, req} !== {4'b0000, 4'b1000}) begin
            errors++;
            $display("FAIL starve_clear got starve=%b req=%b", starve, req);
        end
        drive('0, '0, 4'b1000);
        drive('0, '0, '0);
    endtask

    task automatic test_protocol();
        drive('0, '0, '0, 1'b1);
        drive(4'b0011, {16'h0, 8'h62, 8'h61}, '0);
        drive('0, '0, 4'b0011);
        checks++;
        if ({req, protocol_err} !== {4'b0011, 1'b1}) begin
            errors++;
            $display("FAIL perr_multi got req=%b perr=%b exp req=0011 perr=1", req, protocol_err);
        end
        drive('0, '0, 4'b0001);
        drive('0, '0, 4'b0010);
        drive('0, '0, '0);
        checks++;
        if ({req, protocol_err} !== {4'b0000, perr_m} || protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky got req=%b perr=%b", req, protocol_err);
        end
        drive('0, '0, '0, 1'b1);
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_reset got=%b exp=0", protocol_err);
        end
        drive('0, '0, 4'b0100);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_unreq got=%b exp=1", protocol_err);
        end
        drive('0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        for (int j = 0; j < 3; j++) drive(4'b0011, {16'h0, 8'(8'h90 + j), 8'(8'h80 + j)}, '0);
        drive('0, '0, '0);
        drive('0, '0, 4'b0001);
        drive('0, '0, 4'b0010, 1'b1);
        checks++;
        if ({req, in_ready, starve, protocol_err} !== {4'b0000, 4'b1111, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL midreset got req=%b rdy=%b starve=%b perr=%b",
                     req, in_ready, starve, protocol_err);
        end
        for (int c = 0; c < 3; c++) drive('0, '0, '0);
        drive(4'b0001, {24'h0, 8'hC5}, '0);
        drive('0, '0, 4'b0001);
        drive('0, '0, '0);
        checks++;
        if (req !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_refill got req=%b exp=0000", req);
        end
    endtask

    initial begin
        in_valid = '0;
        in_data  = '0;
        grant    = '0;
        rst      = 1'b1;
        perr_m   = 1'b0;
        test_reset();
        test_fill_drain();
        test_same_cycle();
        test_starvation();
        test_protocol();
        test_reset_midstream();
        drive('0, '0, '0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
